// File: rtl/modport_checker_pkg.sv
// Shared AHB-Lite encodings, rule indices and burst-length helper for the checker.
package modport_checker_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000,
        HB_INCR   = 3'b001,
        HB_WRAP4  = 3'b010,
        HB_INCR4  = 3'b011,
        HB_WRAP8  = 3'b100,
        HB_INCR8  = 3'b101,
        HB_WRAP16 = 3'b110,
        HB_INCR16 = 3'b111
    } hburst_e;

    localparam int NUM_RULES          = 8;
    localparam int ERR_INCR_ADDR      = 0;
    localparam int ERR_WRAP_ADDR      = 1;
    localparam int ERR_CTRL_BURST     = 2;
    localparam int ERR_CTRL_BUSY      = 3;
    localparam int ERR_FIRST_BUSY     = 4;
    localparam int ERR_LAST_BUSY      = 5;
    localparam int ERR_WAIT_CTRL      = 6;
    localparam int ERR_IDLE_AFTER_RST = 7;

    // Remaining beats after the first one; undefined-length INCR counts as 0.
    function automatic logic [3:0] beats_m1(input logic [2:0] hburst);
        case (hburst)
            HB_WRAP4,  HB_INCR4:  beats_m1 = 4'd3;
            HB_WRAP8,  HB_INCR8:  beats_m1 = 4'd7;
            HB_WRAP16, HB_INCR16: beats_m1 = 4'd15;
            default:              beats_m1 = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Tracks remaining beats of a fixed-length burst so a trailing BUSY can be flagged.
module ahb_beat_counter
    import modport_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    output logic [3:0] cnt
);

    logic [3:0] cnt_nxt;

    // Next count: later conditions override earlier ones.
    always_comb begin
        cnt_nxt = cnt;
        if (htrans == HT_IDLE || (htrans == HT_NONSEQ && hburst == HB_INCR))
            cnt_nxt = 4'd0;
        if (htrans == HT_NONSEQ && hburst != HB_INCR && hready)
            cnt_nxt = beats_m1(hburst);
        if (htrans == HT_SEQ && hready)
            cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) cnt <= 4'd0;
        else     cnt <= cnt_nxt;
    end

endmodule

// File: rtl/modport_checker.sv
// Passive AHB-Lite burst/transfer rule checker with per-rule pulse and sticky flags.
module modport_checker
    import modport_checker_pkg::*;
#(
    parameter int INCR_ADDR_BITS = 17
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic        HREADYOUT,
    output logic [7:0]  err,
    output logic [7:0]  err_sticky,
    output logic        err_any
);

    logic [1:0]  prev_htrans;
    logic [2:0]  prev_hburst;
    logic [2:0]  prev_hsize;
    logic        prev_hwrite;
    logic [31:0] prev_haddr;
    logic        prev_ready;
    logic        past_valid;
    logic [3:0]  cnt;

    logic                      continuing, active_prev, beat_adv;
    logic                      is_incr, is_wrap, ctrl_same;
    logic [INCR_ADDR_BITS-1:0] incr_nxt;
    logic [2:0]                aw;
    logic [9:0]                wrap_mask, wrap_nxt;
    logic [7:0]                viol;

    ahb_beat_counter u_cnt (
        .clk    (HCLK),
        .rst    (HRESET),
        .htrans (HTRANS),
        .hburst (HBURST),
        .hready (HREADYOUT),
        .cnt    (cnt)
    );

    // Rule evaluation on current inputs against the previous sample.
    always_comb begin
        continuing  = (HTRANS == HT_BUSY) || (HTRANS == HT_SEQ);
        active_prev = (prev_htrans == HT_NONSEQ) || (prev_htrans == HT_SEQ);
        beat_adv    = prev_ready && continuing && active_prev;
        is_incr     = HBURST[0];
        is_wrap     = !HBURST[0] && (HBURST != HB_SINGLE);
        ctrl_same   = (HSIZE == prev_hsize) && (HBURST == prev_hburst) &&
                      (HWRITE == prev_hwrite) && (HADDR[31:10] == prev_haddr[31:10]);

        incr_nxt  = prev_haddr[INCR_ADDR_BITS-1:0] + (INCR_ADDR_BITS'(1) << HSIZE);
        case (HBURST)
            HB_WRAP8:  aw = 3'd3;
            HB_WRAP16: aw = 3'd4;
            default:   aw = 3'd2;
        endcase
        // Bits above the wrap boundary come from HADDR itself; only the
        // within-boundary offset must follow the incremented previous address.
        wrap_mask = (10'h3FF << HSIZE) << aw;
        wrap_nxt  = prev_haddr[9:0] + (10'd1 << HSIZE);

        viol = 8'd0;
        viol[ERR_INCR_ADDR]  = beat_adv && is_incr &&
                               (HADDR[INCR_ADDR_BITS-1:0] != incr_nxt);
        viol[ERR_WRAP_ADDR]  = beat_adv && is_wrap &&
                               (HADDR[9:0] != ((HADDR[9:0] & wrap_mask) | (wrap_nxt & ~wrap_mask)));
        viol[ERR_CTRL_BURST] = continuing && (prev_htrans != HT_IDLE) && !ctrl_same;
        viol[ERR_CTRL_BUSY]  = continuing && (prev_htrans == HT_BUSY) && !ctrl_same;
        viol[ERR_FIRST_BUSY] = (HTRANS == HT_BUSY) && (prev_htrans == HT_IDLE);
        viol[ERR_LAST_BUSY]  = (cnt == 4'd0) && (HBURST != HB_INCR) && (HTRANS == HT_BUSY);
        viol[ERR_WAIT_CTRL]  = !prev_ready && (HTRANS == prev_htrans) && (prev_htrans != HT_IDLE) &&
                               ((HADDR != prev_haddr) || (HBURST != prev_hburst) ||
                                (HSIZE != prev_hsize) || (HWRITE != prev_hwrite));
        if (!past_valid) viol[6:0] = 7'd0;
        viol[ERR_IDLE_AFTER_RST] = !past_valid && (HTRANS != HT_IDLE);
    end

    // Previous-sample capture and error flag registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            prev_htrans <= HT_IDLE;
            prev_hburst <= 3'd0;
            prev_hsize  <= 3'd0;
            prev_hwrite <= 1'b0;
            prev_haddr  <= 32'd0;
            prev_ready  <= 1'b0;
            past_valid  <= 1'b0;
            err         <= 8'd0;
            err_sticky  <= 8'd0;
        end else begin
            prev_htrans <= HTRANS;
            prev_hburst <= HBURST;
            prev_hsize  <= HSIZE;
            prev_hwrite <= HWRITE;
            prev_haddr  <= HADDR;
            prev_ready  <= HREADYOUT;
            past_valid  <= 1'b1;
            err         <= viol;
            err_sticky  <= err_sticky | viol;
        end
    end

    assign err_any = |err_sticky;

endmodule

// File: tb/tb_modport_checker.sv
// Directed-vector bench for the AHB-Lite rule checker.
module tb_modport_checker;
    import modport_checker_pkg::*;

    logic        HCLK, HRESET, HWRITE, HREADYOUT;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic [31:0] HADDR;
    logic [7:0]  err, err_sticky;
    logic        err_any;

    int n_checks = 0;
    int n_errors = 0;

    modport_checker #(.INCR_ADDR_BITS(17)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HTRANS     (HTRANS),
        .HBURST     (HBURST),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HADDR      (HADDR),
        .HREADYOUT  (HREADYOUT),
        .err        (err),
        .err_sticky (err_sticky),
        .err_any    (err_any)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one bus sample, let it be clocked in, settle just past the edge.
    task automatic step(input logic [1:0] t, input logic [2:0] b, input logic [2:0] sz,
                        input logic wr, input logic [31:0] a, input logic rdy);
        HTRANS = t; HBURST = b; HSIZE = sz; HWRITE = wr; HADDR = a; HREADYOUT = rdy;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle();
        step(HT_IDLE, HB_SINGLE, 3'd2, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        idle();
        idle();
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        HTRANS = HT_IDLE; HBURST = HB_SINGLE; HSIZE = 3'd2;
        HWRITE = 1'b0; HADDR = 32'h0; HREADYOUT = 1'b1;
        do_reset();
        check("rst_err", {24'd0, err}, 32'h0);
        check("rst_sticky", {24'd0, err_sticky}, 32'h0);
        check("rst_any", {31'd0, err_any}, 32'h0);

        // First cycle after reset must be IDLE
        step(HT_NONSEQ, HB_SINGLE, 3'd2, 1'b0, 32'h100, 1'b1);
        check("idle_after_rst", {24'd0, err}, 32'h80);
        idle();
        check("idle_after_rst_pulse", {24'd0, err}, 32'h0);
        do_reset();
        idle();
        check("idle_first_ok", {24'd0, err_sticky}, 32'h0);

        // Clean INCR4 word burst
        step(HT_NONSEQ, HB_INCR4, 3'd2, 1'b0, 32'h100, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h104, 1'b1);
        check("incr4_b1", {24'd0, err}, 32'h0);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h108, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h10C, 1'b1);
        check("incr4_clean", {24'd0, err_sticky}, 32'h0);
        idle();

        // INCR4 with skipped address
        step(HT_NONSEQ, HB_INCR4, 3'd2, 1'b0, 32'h100, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h104, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h10C, 1'b1);
        check("incr_addr", {24'd0, err}, 32'h01);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h110, 1'b1);
        check("incr_addr_pulse", {24'd0, err}, 32'h0);
        idle();

        do_reset();
        idle();
        // Clean WRAP4 word burst from 0x38
        step(HT_NONSEQ, HB_WRAP4, 3'd2, 1'b0, 32'h38, 1'b1);
        step(HT_SEQ,    HB_WRAP4, 3'd2, 1'b0, 32'h3C, 1'b1);
        step(HT_SEQ,    HB_WRAP4, 3'd2, 1'b0, 32'h30, 1'b1);
        check("wrap4_wrap_beat", {24'd0, err}, 32'h0);
        step(HT_SEQ,    HB_WRAP4, 3'd2, 1'b0, 32'h34, 1'b1);
        check("wrap4_clean", {24'd0, err_sticky}, 32'h0);
        idle();
        // WRAP4 with wrong offset after wrap point (0x34 instead of 0x30)
        step(HT_NONSEQ, HB_WRAP4, 3'd2, 1'b0, 32'h38, 1'b1);
        step(HT_SEQ,    HB_WRAP4, 3'd2, 1'b0, 32'h3C, 1'b1);
        step(HT_SEQ,    HB_WRAP4, 3'd2, 1'b0, 32'h34, 1'b1);
        check("wrap_addr", {24'd0, err}, 32'h02);
        idle();

        // BUSY straight after IDLE (INCR so the last-beat rule stays quiet)
        step(HT_BUSY, HB_INCR, 3'd2, 1'b0, 32'h100, 1'b1);
        check("first_busy", {24'd0, err}, 32'h10);
        idle();

        // BUSY after the final beat of INCR4
        step(HT_NONSEQ, HB_INCR4, 3'd2, 1'b0, 32'h100, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h104, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h108, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h10C, 1'b1);
        check("incr4_last_beat", {24'd0, err}, 32'h0);
        step(HT_BUSY,   HB_INCR4, 3'd2, 1'b0, 32'h110, 1'b1);
        check("last_busy", {24'd0, err}, 32'h20);
        idle();

        // BUSY inside an undefined-length INCR is legal
        step(HT_NONSEQ, HB_INCR, 3'd2, 1'b0, 32'h100, 1'b1);
        step(HT_SEQ,    HB_INCR, 3'd2, 1'b0, 32'h104, 1'b1);
        step(HT_BUSY,   HB_INCR, 3'd2, 1'b0, 32'h108, 1'b1);
        check("incr_busy_ok", {24'd0, err}, 32'h0);
        idle();

        // Address changed while the slave stalls
        step(HT_NONSEQ, HB_SINGLE, 3'd2, 1'b0, 32'h200, 1'b0);
        check("wait_first", {24'd0, err}, 32'h0);
        step(HT_NONSEQ, HB_SINGLE, 3'd2, 1'b0, 32'h204, 1'b1);
        check("wait_ctrl", {24'd0, err}, 32'h40);
        idle();

        // HWRITE toggled mid-burst
        step(HT_NONSEQ, HB_INCR4, 3'd2, 1'b0, 32'h100, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b1, 32'h104, 1'b1);
        check("ctrl_burst", {24'd0, err}, 32'h04);
        idle();

        // HSIZE changed on the SEQ following BUSY
        step(HT_NONSEQ, HB_INCR, 3'd2, 1'b0, 32'h100, 1'b1);
        step(HT_BUSY,   HB_INCR, 3'd2, 1'b0, 32'h104, 1'b1);
        check("busy_ok", {24'd0, err}, 32'h0);
        step(HT_SEQ,    HB_INCR, 3'd1, 1'b0, 32'h104, 1'b1);
        check("ctrl_busy", {24'd0, err}, 32'h0C);
        idle();

        // Reset mid-burst: next cycle is treated as first-after-reset
        step(HT_NONSEQ, HB_INCR4, 3'd2, 1'b0, 32'h100, 1'b1);
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h104, 1'b1);
        HRESET = 1'b1;
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h108, 1'b1);
        check("rst_mid_err", {24'd0, err}, 32'h0);
        check("rst_mid_sticky", {24'd0, err_sticky}, 32'h0);
        HRESET = 1'b0;
        step(HT_SEQ,    HB_INCR4, 3'd2, 1'b0, 32'h10C, 1'b1);
        check("rst_mid_first", {24'd0, err}, 32'h80);

        // Sticky persistence and clear
        do_reset();
        idle();
        step(HT_BUSY, HB_INCR, 3'd2, 1'b0, 32'h100, 1'b1);
        for (int i = 0; i < 10; i++) idle();
        check("sticky_hold_err", {24'd0, err}, 32'h0);
        check("sticky_hold", {24'd0, err_sticky}, 32'h10);
        check("sticky_any", {31'd0, err_any}, 32'h1);
        HRESET = 1'b1;
        idle();
        HRESET = 1'b0;
        check("sticky_clr", {24'd0, err_sticky}, 32'h0);
        check("sticky_any_clr", {31'd0, err_any}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
